// File: rtl/speed_ctrl.sv
// speed_ctrl: debounced faster/slower/pause buttons driving a saturating 2-bit speed level.
// Define SPEED_CTRL_AUTO_EN to also raise the level once every AUTO_STEP score pulses.
module speed_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int INIT_LEVEL      = 1,
  parameter int AUTO_STEP       = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_pause,
  input  logic       score_pulse,
  output logic [1:0] level,
  output logic [1:0] clk_rate,
  output logic       run_en,
  output logic       level_up
);

  localparam int              CW       = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [1:0]      INIT_LVL = 2'(INIT_LEVEL);

  typedef enum logic {RUN, PAUSED} run_state_t;

  // Bit order in every per-button vector: [0] up, [1] down, [2] pause.
  logic [2:0] btn_raw;
  logic [2:0] sync1;
  logic [2:0] sync2;
  logic [2:0] deb;
  logic [2:0] deb_d;
  logic [2:0] press;

  run_state_t state;
  run_state_t state_next;
  logic       auto_inc;
  logic [2:0] level_sum;
  logic [1:0] level_next;

  assign btn_raw = {btn_pause, btn_down, btn_up};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      deb_d <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      deb_d <= deb;
    end
  end

  for (genvar i = 0; i < 3; i++) begin : g_deb
    logic [CW-1:0] cnt_q;
    logic          deb_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q <= '0;
        deb_q <= 1'b0;
      end else if (sync2[i] == deb_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        deb_q <= sync2[i];
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end

    assign deb[i] = deb_q;
  end

  assign press = deb & ~deb_d;

`ifdef SPEED_CTRL_AUTO_EN
  logic [7:0] auto_cnt;
  logic       auto_hit;

  // Score pulses only count while the game is running.
  assign auto_hit = score_pulse && run_en;
  assign auto_inc = auto_hit && (auto_cnt == 8'(AUTO_STEP - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      auto_cnt <= '0;
    end else if (auto_hit) begin
      auto_cnt <= auto_inc ? 8'd0 : auto_cnt + 8'd1;
    end
  end
`else
  localparam int auto_step_unused = AUTO_STEP;
  logic score_unused;

  assign score_unused = score_pulse;
  assign auto_inc     = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (press[2]) begin
      state_next = (state == RUN) ? PAUSED : RUN;
    end
  end

  assign run_en = (state == RUN);

  // Add the increments first, then the saturating decrement, so up+down cancels.
  always_comb begin
    level_sum = {1'b0, level} + {2'b00, press[0]} + {2'b00, auto_inc};
    if (press[1] && (level_sum != 3'd0)) begin
      level_sum = level_sum - 3'd1;
    end
    level_next = (level_sum > 3'd3) ? 2'd3 : level_sum[1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level    <= INIT_LVL;
      clk_rate <= ~INIT_LVL;
      level_up <= 1'b0;
    end else begin
      level    <= level_next;
      clk_rate <= ~level_next;
      level_up <= (level_next > level);
    end
  end

endmodule
